// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: 2-bit saturating counters plus a tagged BTB, trained from execute.
// Also produces the registered mispredict/redirect pulse for the fetch/flush logic.
module branch_predictor #(
  parameter int unsigned IndexBits = 6,
  parameter int unsigned TagBits   = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] fetch_pc_i,
  output logic        predict_taken_o,
  output logic [31:0] predict_target_o,
  output logic        ready_o,
  input  logic        update_valid_i,
  input  logic [31:0] update_pc_i,
  input  logic [6:0]  update_opcode_i,
  input  logic        update_taken_i,
  input  logic [31:0] update_target_i,
  input  logic        update_pred_taken_i,
  input  logic [31:0] update_pred_target_i,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o
);

  localparam int unsigned Entries  = 2 ** IndexBits;
  localparam logic [6:0]  OpBranch = 7'b1100011;

  typedef enum logic {StInit, StReady} state_e;

  state_e               state_q;
  logic [IndexBits-1:0] init_idx_q;
  logic                 mispredict_q, mispredict_d;
  logic [31:0]          redirect_q, redirect_d;

  logic [1:0]         ctr_q        [Entries];
  logic               btb_valid_q  [Entries];
  logic [TagBits-1:0] btb_tag_q    [Entries];
  logic [31:0]        btb_target_q [Entries];

  logic [IndexBits-1:0] f_idx, u_idx, wr_idx;
  logic [TagBits-1:0]   f_tag, u_tag;
  logic                 pred_hit, upd_branch;
  logic [1:0]           ctr_cur, ctr_wdata;
  logic                 ctr_we, valid_we, valid_wdata, btb_we;

  assign f_idx   = fetch_pc_i[IndexBits+1:2];
  assign f_tag   = fetch_pc_i[IndexBits+TagBits+1:IndexBits+2];
  assign u_idx   = update_pc_i[IndexBits+1:2];
  assign u_tag   = update_pc_i[IndexBits+TagBits+1:IndexBits+2];
  assign ready_o = (state_q == StReady);

  // Lookup reads the arrays directly, so a same-cycle update is not bypassed.
  always_comb begin
    pred_hit = ready_o && ctr_q[f_idx][1] && btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_tag);
    predict_taken_o  = pred_hit;
    predict_target_o = pred_hit ? btb_target_q[f_idx] : fetch_pc_i + 32'd4;
  end

  assign upd_branch = ready_o && update_valid_i && (update_opcode_i == OpBranch);

  always_comb begin
    ctr_cur = ctr_q[u_idx];
    if (update_taken_i) begin
      ctr_wdata = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'd1;
    end else begin
      ctr_wdata = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'd1;
    end
    ctr_we      = 1'b0;
    valid_we    = 1'b0;
    valid_wdata = 1'b0;
    btb_we      = 1'b0;
    wr_idx      = u_idx;
    if (!reset_i) begin
      if (state_q == StInit) begin
        ctr_we    = 1'b1;
        ctr_wdata = 2'b01;
        valid_we  = 1'b1;
        wr_idx    = init_idx_q;
      end else if (upd_branch) begin
        ctr_we      = 1'b1;
        valid_we    = update_taken_i;
        valid_wdata = 1'b1;
        btb_we      = update_taken_i;
      end
    end
  end

  always_comb begin
    mispredict_d = upd_branch &&
                   ((update_taken_i != update_pred_taken_i) ||
                    (update_taken_i && update_pred_taken_i &&
                     (update_target_i != update_pred_target_i)));
    redirect_d   = redirect_q;
    if (mispredict_d) begin
      redirect_d = update_taken_i ? update_target_i : update_pc_i + 32'd4;
    end
  end

  // Table storage has no reset; INIT sweeps it instead.
  always_ff @(posedge clk_i) begin
    if (ctr_we) ctr_q[wr_idx] <= ctr_wdata;
    if (valid_we) btb_valid_q[wr_idx] <= valid_wdata;
    if (btb_we) begin
      btb_tag_q[wr_idx]    <= u_tag;
      btb_target_q[wr_idx] <= update_target_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StInit;
      init_idx_q   <= '0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      if (state_q == StInit) begin
        init_idx_q <= init_idx_q + IndexBits'(1);
        if (&init_idx_q) state_q <= StReady;
      end
    end
  end

  assign mispredict_o  = mispredict_q;
  assign redirect_pc_o = redirect_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios then random traffic against a table-level model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        ready;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [6:0]  upd_opcode;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk_i                (clk),
    .reset_i              (reset),
    .fetch_pc_i           (fetch_pc),
    .predict_taken_o      (predict_taken),
    .predict_target_o     (predict_target),
    .ready_o              (ready),
    .update_valid_i       (upd_valid),
    .update_pc_i          (upd_pc),
    .update_opcode_i      (upd_opcode),
    .update_taken_i       (upd_taken),
    .update_target_i      (upd_target),
    .update_pred_taken_i  (upd_pred_taken),
    .update_pred_target_i (upd_pred_target),
    .mispredict_o         (mispredict),
    .redirect_pc_o        (redirect_pc)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: whole table conceptually reinitialised at reset, usable after 64 cycles.
  int          m_ctr   [64];
  bit          m_valid [64];
  logic [7:0]  m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_cycles;
  bit          m_misp;
  logic [31:0] m_redir;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_ctr[i]   = 1;
      m_valid[i] = 1'b0;
    end
    m_cycles = 0;
    m_misp   = 1'b0;
    m_redir  = 32'h0;
  endtask

  task automatic model_predict(input logic [31:0] pc, output logic taken, output logic [31:0] tgt);
    int idx;
    idx   = int'(pc[7:2]);
    taken = (m_cycles >= 64) && (m_ctr[idx] >= 2) && m_valid[idx] && (m_tag[idx] == pc[15:8]);
    tgt   = taken ? m_tgt[idx] : pc + 32'd4;
  endtask

  // One clock: check lookup, clock the DUT, advance the model, check registered outputs.
  task automatic cycle();
    logic        pt;
    logic [31:0] ptgt;
    bit          br, nm;
    logic [31:0] nr;
    int          idx;
    #1;
    model_predict(fetch_pc, pt, ptgt);
    check_eq("predict_taken", {31'b0, predict_taken}, {31'b0, pt});
    check_eq("predict_target", predict_target, ptgt);
    br = !reset && (m_cycles >= 64) && upd_valid && (upd_opcode == 7'b1100011);
    nm = br && ((upd_taken != upd_pred_taken) ||
                (upd_taken && (upd_target != upd_pred_target)));
    nr = nm ? (upd_taken ? upd_target : upd_pc + 32'd4) : m_redir;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      if (m_cycles < 64) m_cycles++;
      if (br) begin
        idx = int'(upd_pc[7:2]);
        if (upd_taken) begin
          if (m_ctr[idx] < 3) m_ctr[idx]++;
          m_valid[idx] = 1'b1;
          m_tag[idx]   = upd_pc[15:8];
          m_tgt[idx]   = upd_target;
        end else if (m_ctr[idx] > 0) begin
          m_ctr[idx]--;
        end
      end
      m_misp  = nm;
      m_redir = nr;
    end
    #1;
    check_eq("mispredict", {31'b0, mispredict}, {31'b0, m_misp});
    check_eq("redirect_pc", redirect_pc, m_redir);
    check_eq("ready", {31'b0, ready}, {31'b0, m_cycles >= 64});
  endtask

  task automatic set_upd(input bit v, input logic [31:0] pc, input logic [6:0] op, input bit t,
                         input logic [31:0] tg, input bit pt, input logic [31:0] ptg);
    upd_valid       = v;
    upd_pc          = pc;
    upd_opcode      = op;
    upd_taken       = t;
    upd_target      = tg;
    upd_pred_taken  = pt;
    upd_pred_target = ptg;
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(1, 2)) << 8) | (32'($urandom_range(0, 3)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  localparam logic [6:0] Beq = 7'b1100011;

  initial begin
    reset    = 1'b1;
    fetch_pc = 32'h100;
    set_upd(1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    model_reset();
    check_eq("reset_ready", {31'b0, ready}, 32'h0);
    check_eq("reset_mispredict", {31'b0, mispredict}, 32'h0);
    check_eq("reset_redirect", redirect_pc, 32'h0);

    // Initialisation sweep with a live fetch PC.
    reset = 1'b0;
    for (int i = 0; i < 64; i++) cycle();
    check_eq("ready_after_init", {31'b0, ready}, 32'h1);

    // First taken branch, predicted not taken.
    set_upd(1'b1, 32'h100, Beq, 1'b1, 32'h80, 1'b0, 32'h0);
    cycle();
    check_eq("first_redirect", redirect_pc, 32'h80);
    set_upd(1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle();
    check_eq("trained_target", predict_target, 32'h80);

    // Saturate, then two not-taken updates.
    set_upd(1'b1, 32'h100, Beq, 1'b1, 32'h80, 1'b1, 32'h80);
    for (int i = 0; i < 3; i++) cycle();
    set_upd(1'b1, 32'h100, Beq, 1'b0, 32'h80, 1'b1, 32'h80);
    cycle();
    check_eq("nt_redirect", redirect_pc, 32'h104);
    cycle();
    set_upd(1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle();
    check_eq("after_two_nt", {31'b0, predict_taken}, 32'h0);

    // Tag alias and non-branch opcode.
    set_upd(1'b1, 32'h100, Beq, 1'b1, 32'h80, 1'b0, 32'h0);
    cycle();
    cycle();
    fetch_pc = 32'h200;
    set_upd(1'b1, 32'h200, 7'b0110011, 1'b1, 32'h90, 1'b0, 32'h0);
    cycle();
    fetch_pc = 32'h100;
    cycle();

    // Correct vs wrong predicted target.
    set_upd(1'b1, 32'h100, Beq, 1'b1, 32'h80, 1'b1, 32'h80);
    cycle();
    set_upd(1'b1, 32'h100, Beq, 1'b1, 32'h80, 1'b1, 32'h90);
    cycle();
    check_eq("wrong_target_redirect", redirect_pc, 32'h80);

    // Reset coincident with a mispredicting update.
    reset = 1'b1;
    set_upd(1'b1, 32'h100, Beq, 1'b0, 32'h0, 1'b1, 32'h80);
    cycle();
    reset = 1'b0;
    set_upd(1'b0, 32'h0, 7'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 64; i++) cycle();
    cycle();
    check_eq("retrain_lost", {31'b0, predict_taken}, 32'h0);

    // Random traffic with aliasing PCs and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 499) == 0);
      fetch_pc   = rand_pc();
      upd_valid  = ($urandom_range(0, 3) != 0);
      upd_pc     = rand_pc();
      upd_opcode = ($urandom_range(0, 4) == 0) ? 7'($urandom) : Beq;
      upd_taken  = 1'($urandom_range(0, 1));
      upd_target = 32'h40 * 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        model_predict(upd_pc, upd_pred_taken, upd_pred_target);
      end else begin
        upd_pred_taken  = 1'($urandom_range(0, 1));
        upd_pred_target = 32'h40 * 32'($urandom_range(0, 3));
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
